// File: rtl/hint_reveal_scheduler_if.sv
// hint_reveal_scheduler_if: game-state inputs and hint outputs shared by the scheduler and its neighbours
interface hint_reveal_scheduler_if;
  logic        game_start;
  logic        new_game;
  logic        word_correct;
  logic        timer_done;
  logic [24:0] word_in;
  logic [4:0]  hint_mask;
  logic [2:0]  hint_count;
  logic        hint_pulse;
  logic        hint_active;
  logic [1:0]  state_o;
  modport master (
    output game_start, new_game, word_correct, timer_done, word_in,
    input  hint_mask, hint_count, hint_pulse, hint_active, state_o
  );
  modport slave (
    input  game_start, new_game, word_correct, timer_done, word_in,
    output hint_mask, hint_count, hint_pulse, hint_active, state_o
  );
endinterface

// File: rtl/hint_reveal_scheduler.sv
// hint_reveal_scheduler: times hint reveals and picks which letter of the latched target word to uncover
module hint_reveal_scheduler #(
  parameter int         CLK_HZ          = 100_000_000,
  parameter int         FIRST_DELAY_S   = 60,
  parameter int         HINT_INTERVAL_S = 25,
  parameter int         MAX_HINTS       = 4,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input logic                    clk,
  input logic                    reset,
  hint_reveal_scheduler_if.slave bus
);
  localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SMAX = (FIRST_DELAY_S > HINT_INTERVAL_S) ? FIRST_DELAY_S : HINT_INTERVAL_S;
  localparam int SW   = $clog2(SMAX + 1);
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sec_q, sec_d, sec_target;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [24:0]   word_q, word_d;
  logic [4:0]    mask_q, mask_d, elig, pick;
  logic [2:0]    count_q, count_d, start, idx, sel;
  logic          pulse_q, pulse_d, game_start_q, game_start_d;
  logic          sec_tick, hint_due, found, active;
  // elig is indexed by letter number; mask bit 4-i belongs to letter i
  for (genvar i = 0; i < 5; i++) begin : g_elig
    assign elig[i] = (word_q[24-5*i -: 5] != 5'd0) && !mask_q[4-i];
  end
  // scanning from the highest offset down leaves the first eligible letter after start in sel
  always_comb begin
    start = (lfsr_q[2:0] >= 3'd5) ? lfsr_q[2:0] - 3'd5 : lfsr_q[2:0];
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      idx   = 3'((int'(start) + k) % 5);
      sel   = elig[idx] ? idx : sel;
      found = found | elig[idx];
    end
    pick = 5'b10000 >> sel;
  end
  always_comb begin
    active       = (state_q == WAIT_FIRST) || (state_q == RUN);
    sec_tick     = presc_q == PW'(CLK_HZ - 1);
    sec_target   = SW'((state_q == WAIT_FIRST) ? FIRST_DELAY_S : HINT_INTERVAL_S);
    hint_due     = sec_tick && (sec_q + SW'(1) == sec_target);
    state_d      = state_q;
    mask_d       = mask_q;
    count_d      = count_q;
    word_d       = word_q;
    pulse_d      = 1'b0;
    game_start_d = bus.game_start;
    lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (bus.new_game) begin
      state_d = IDLE;
      mask_d  = '0;
      count_d = '0;
    end else if (state_q == IDLE) begin
      if (bus.game_start && !game_start_q) begin
        state_d = WAIT_FIRST;
        mask_d  = '0;
        count_d = '0;
        word_d  = bus.word_in;
      end
    end else if (active) begin
      if (bus.word_correct || bus.timer_done || count_q == 3'(MAX_HINTS))
        state_d = DONE;
      else if (hint_due) begin
        state_d = found ? RUN : DONE;
        mask_d  = mask_q | (found ? pick : 5'd0);
        count_d = count_q + 3'(found);
        pulse_d = found;
      end
    end
    presc_d = (state_d != state_q || sec_tick) ? '0 : presc_q + PW'(1);
    sec_d   = (!active || state_d != state_q || pulse_d) ? '0 : sec_q + SW'(sec_tick);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      sec_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      word_q       <= '0;
      mask_q       <= '0;
      count_q      <= '0;
      pulse_q      <= 1'b0;
      game_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      sec_q        <= sec_d;
      lfsr_q       <= lfsr_d;
      word_q       <= word_d;
      mask_q       <= mask_d;
      count_q      <= count_d;
      pulse_q      <= pulse_d;
      game_start_q <= game_start_d;
    end
  end
  assign bus.hint_mask   = mask_q;
  assign bus.hint_count  = count_q;
  assign bus.hint_pulse  = pulse_q;
  assign bus.hint_active = state_q == RUN;
  assign bus.state_o     = state_q;
endmodule

// File: tb/tb_hint_reveal_scheduler.sv
// tb_hint_reveal_scheduler: scoreboard bench; a reference model predicts hints from elapsed-time rules,
// a monitor pops predictions whenever the DUT pulses, and directed rounds pin the absolute hint timing.
module tb_hint_reveal_scheduler;
  localparam int         CLK_HZ = 10, FD = 3, HI = 2, MAXH = 4;
  localparam logic [7:0] SEED   = 8'hA5;
  typedef struct { logic [4:0] mask; int count; } exp_t;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  hint_reveal_scheduler_if bus();
  hint_reveal_scheduler #(
    .CLK_HZ(CLK_HZ), .FIRST_DELAY_S(FD), .HINT_INTERVAL_S(HI), .MAX_HINTS(MAXH), .LFSR_SEED(SEED)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0, passed = 0, cyc = 0;
  int m_state, m_count, m_e;
  logic [4:0]  m_mask;
  logic [24:0] m_word;
  logic [7:0]  m_lfsr;
  logic        m_pulse, m_prev_gs;
  exp_t sb[$];
  int   stamps[$];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // first letter at or after start (mod 5) that is non-empty and not yet revealed; -1 if none
  function automatic int pick_letter(input logic [2:0] r);
    for (int k = 0; k < 5; k++) begin
      int l;
      l = (int'(r) % 5 + k) % 5;
      if (m_word[24-5*l -: 5] != 5'd0 && !m_mask[4-l]) return l;
    end
    return -1;
  endfunction

  // m_e counts clock cycles since the current wait began; a hint is due once the
  // wait has lasted the required number of seconds times CLK_HZ
  task automatic model_step();
    logic       rise;
    logic [2:0] r;
    int         l;
    rise      = bus.game_start && !m_prev_gs;
    r         = m_lfsr[2:0];
    m_prev_gs = bus.game_start;
    m_lfsr    = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_pulse   = 1'b0;
    if (bus.new_game) begin
      m_state = 0; m_mask = '0; m_count = 0;
    end else if (m_state == 0) begin
      if (rise) begin m_state = 1; m_mask = '0; m_count = 0; m_word = bus.word_in; m_e = 0; end
    end else if (m_state != 3) begin
      if (bus.word_correct || bus.timer_done || m_count == MAXH) m_state = 3;
      else if (m_e + 1 == ((m_state == 1) ? FD : HI) * CLK_HZ) begin
        l = pick_letter(r);
        if (l < 0) m_state = 3;
        else begin
          m_mask[4-l] = 1'b1;
          m_count++;
          m_pulse = 1'b1;
          m_state = 2;
          m_e     = 0;
          sb.push_back('{m_mask, m_count});
        end
      end else m_e++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_state = 0; m_mask = '0; m_count = 0; m_e = 0; m_pulse = 1'b0;
      m_prev_gs = 1'b0; m_lfsr = SEED; m_word = '0;
      sb.delete();
    end else model_step();
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("state", 32'(bus.state_o), m_state);
        check("active", 32'(bus.hint_active), 32'(m_state == 2));
        check("mask", 32'(bus.hint_mask), 32'(m_mask));
        check("count", 32'(bus.hint_count), m_count);
        check("pulse", 32'(bus.hint_pulse), 32'(m_pulse));
        if (bus.hint_pulse) begin
          stamps.push_back(cyc);
          check("sb_depth", sb.size(), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_mask", 32'(bus.hint_mask), 32'(e.mask));
            check("sb_count", 32'(bus.hint_count), e.count);
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_new_game();
    bus.new_game   = 1'b1;
    bus.game_start = 1'b0;
    cycles(1);
    bus.new_game   = 1'b0;
  endtask

  initial begin
    int t0;
    bus.game_start = 1'b0; bus.new_game = 1'b0; bus.word_correct = 1'b0;
    bus.timer_done = 1'b0; bus.word_in = '0;
    cycles(3);
    check("rst_mask", 32'(bus.hint_mask), 0);
    check("rst_count", 32'(bus.hint_count), 0);
    check("rst_pulse", 32'(bus.hint_pulse), 0);
    check("rst_active", 32'(bus.hint_active), 0);
    check("rst_state", 32'(bus.state_o), 0);
    reset = 1'b0;
    cycles(3);
    // full round: hints at 31, 51, 71, 91 then DONE
    bus.word_in = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    bus.game_start = 1'b1; t0 = cyc; stamps.delete();
    cycles(91);
    check("s1_state91", 32'(bus.state_o), 2);
    check("s1_count91", 32'(bus.hint_count), 4);
    cycles(1);
    check("s1_state92", 32'(bus.state_o), 3);
    check("s1_bits", $countones(bus.hint_mask), 4);
    check("s1_npulse", stamps.size(), 4);
    foreach (stamps[i]) check("s1_stamp", stamps[i] - t0, 31 + 20 * i);
    cycles(10);
    check("s1_held", 32'(bus.hint_count), 4);
    // new_game in DONE
    pulse_new_game();
    check("ng_state", 32'(bus.state_o), 0);
    check("ng_mask", 32'(bus.hint_mask), 0);
    check("ng_count", 32'(bus.hint_count), 0);
    // word_correct at cycle 40 of a fresh round
    cycles(2);
    bus.game_start = 1'b1; t0 = cyc; stamps.delete();
    cycles(40);
    bus.word_correct = 1'b1;
    cycles(1);
    bus.word_correct = 1'b0;
    check("s2_active41", 32'(bus.hint_active), 0);
    check("s2_state41", 32'(bus.state_o), 3);
    cycles(30);
    check("s2_count", 32'(bus.hint_count), 1);
    check("s2_bits", $countones(bus.hint_mask), 1);
    check("s2_npulse", stamps.size(), 1);
    if (stamps.size() > 0) check("s2_stamp", stamps[0] - t0, 31);
    // game_start edge together with new_game stays IDLE
    pulse_new_game();
    cycles(2);
    bus.game_start = 1'b1; bus.new_game = 1'b1; stamps.delete();
    cycles(1);
    bus.new_game = 1'b0;
    cycles(40);
    check("s7_state", 32'(bus.state_o), 0);
    check("s7_npulse", stamps.size(), 0);
    bus.game_start = 1'b0;
    // empty letters 2 and 4: three hints then no eligible letter; late word_in change ignored
    cycles(2);
    bus.word_in = {5'd7, 5'd9, 5'd0, 5'd11, 5'd0};
    bus.game_start = 1'b1; t0 = cyc; stamps.delete();
    cycles(5);
    bus.word_in = {5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
    cycles(86);
    check("s4_state", 32'(bus.state_o), 3);
    check("s4_count", 32'(bus.hint_count), 3);
    check("s4_mask", 32'(bus.hint_mask), 32'(5'b11010));
    check("s4_npulse", stamps.size(), 3);
    pulse_new_game();
    // asynchronous reset mid-RUN
    cycles(2);
    bus.word_in = {5'd3, 5'd3, 5'd3, 5'd3, 5'd3};
    bus.game_start = 1'b1;
    cycles(35);
    check("s6_pre_state", 32'(bus.state_o), 2);
    #1 reset = 1'b1;
    #1;
    check("s6_mask", 32'(bus.hint_mask), 0);
    check("s6_count", 32'(bus.hint_count), 0);
    check("s6_active", 32'(bus.hint_active), 0);
    check("s6_state", 32'(bus.state_o), 0);
    check("s6_pulse", 32'(bus.hint_pulse), 0);
    bus.game_start = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(2);
    // randomized rounds checked by the model and scoreboard
    for (int r = 0; r < 30; r++) begin
      logic [24:0] w;
      for (int j = 0; j < 5; j++)
        w[24-5*j -: 5] = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      bus.word_in = w;
      bus.game_start = 1'b1;
      repeat ($urandom_range(120, 20)) begin
        bus.word_correct = ($urandom_range(99) == 0);
        bus.timer_done   = ($urandom_range(149) == 0);
        bus.new_game     = ($urandom_range(199) == 0);
        if ($urandom_range(9) == 0) bus.word_in = 25'($urandom);
        if ($urandom_range(39) == 0) bus.game_start = ~bus.game_start;
        cycles(1);
      end
      bus.word_correct = 1'b0;
      bus.timer_done   = 1'b0;
      pulse_new_game();
      cycles(1);
    end
    cycles(5);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
